// File: rtl/ifetch_queue_if.sv
// Fetch-side bundle of the instruction prefetch queue: memory fetch handshake and IR handoff.
// master: queue side (drives mem_req/mem_addr/ir_*); slave: memory plus consumer side.
interface ifetch_queue_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_take;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_data,
        output ir_valid, ir_data, ir_pc,
        input  ir_take
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_data,
        input  ir_valid, ir_data, ir_pc,
        output ir_take
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue ahead of the IR: DEPTH {word, pc} entries, flush redirects fetch.
// Ports: clk, reset (async low), bus (ifetch_queue_if.master), flush/flush_pc, count, odd_trap.
// Define IFETCH_ODD_TRAP_EN to trap odd redirect addresses instead of rounding them down.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'o000000
) (
    input  logic                   clk,
    input  logic                   reset,
    ifetch_queue_if.master         bus,
    input  logic                   flush,
    input  logic [15:0]            flush_pc,
    output logic [$clog2(DEPTH):0] count,
    output logic                   odd_trap
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   word_q [DEPTH];
    logic [15:0]   pc_q   [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [15:0]   fpc_q;
    logic          trap_q;
    logic          push;
    logic          pop;

    assign bus.mem_req  = reset && (count_q != CW'(DEPTH)) && !trap_q;
    assign bus.mem_addr = fpc_q;
    assign bus.ir_valid = (count_q != '0);
    assign bus.ir_data  = word_q[head_q];
    assign bus.ir_pc    = pc_q[head_q];
    assign count        = count_q;
    assign odd_trap     = trap_q;

    assign push = bus.mem_req && bus.mem_ack && !flush;
    assign pop  = bus.ir_take && bus.ir_valid && !flush;

    // push and pop exclude flush, so the arms are mutually exclusive
    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            flush:          count_d = '0;
            push && !pop:   count_d = count_q + 1'b1;
            !push && pop:   count_d = count_q - 1'b1;
            default:        count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fpc_q   <= RESET_PC;
        end else begin
            count_q <= count_d;
            if (flush) begin
                head_q <= '0;
                tail_q <= '0;
`ifdef IFETCH_ODD_TRAP_EN
                // an odd target freezes fetch at the old pc
                if (!flush_pc[0]) fpc_q <= flush_pc;
`else
                fpc_q <= {flush_pc[15:1], 1'b0};
`endif
            end else begin
                if (push) begin
                    tail_q <= tail_q + 1'b1;
                    fpc_q  <= fpc_q + 16'd2;
                end
                if (pop) head_q <= head_q + 1'b1;
            end
        end
    end

`ifdef IFETCH_ODD_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     trap_q <= 1'b0;
        else if (flush) trap_q <= flush_pc[0];
    end
`else
    logic unused_flush_lsb;
    assign unused_flush_lsb = flush_pc[0];
    assign trap_q = 1'b0;
`endif

    // storage carries no reset; contents are only meaningful under count
    always_ff @(posedge clk) begin
        if (push) begin
            word_q[tail_q] <= bus.mem_data;
            pc_q[tail_q]   <= fpc_q;
        end
    end
endmodule
